// File: rtl/riscv_defines.sv
// riscv_defines: shared definitions for the EX-stage divider.
// Opcode bit positions, FSM state encoding and op aliases.
package riscv_defines;

  localparam int DIV_OP_SIGNED_BIT = 0;
  localparam int DIV_OP_REM_BIT    = 1;

  localparam logic [1:0] DIV_OP_DIVU = 2'b00;
  localparam logic [1:0] DIV_OP_DIV  = 2'b01;
  localparam logic [1:0] DIV_OP_REMU = 2'b10;
  localparam logic [1:0] DIV_OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_PREP,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/riscv_div_lzc.sv
// riscv_div_lzc: leading-zero counter for divider normalisation.
// An all-zero input returns WIDTH.
module riscv_div_lzc #(
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    cnt_o
);

  // highest set bit wins, so the last match in an upward scan decides
  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        cnt_o = CW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/riscv_div_seq.sv
// riscv_div_seq: multi-cycle DIV/DIVU/REM/REMU unit for EX.
// Restoring divider, optional early-out, valid/ready result.
module riscv_div_seq
  import riscv_defines::*;
#(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 2 * WIDTH;

  localparam logic [WIDTH-1:0] MIN_VAL =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = '1;

  div_state_t       state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [DW-1:0]    dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [WIDTH-1:0] result_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             sgn;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [CW-1:0]    lz_a;
  logic [CW-1:0]    lz_b;
  logic             div_zero;
  logic             ovf;
  logic [CW-1:0]    n_iter;
  logic [CW-1:0]    n_sh;
  logic [DW-1:0]    dvs_init;

  logic             step_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  if (EARLY_OUT != 0) begin : g_lzc
    riscv_div_lzc #(.WIDTH(WIDTH)) u_lzc_a (
      .data_i (abs_a),
      .cnt_o  (lz_a)
    );
    riscv_div_lzc #(.WIDTH(WIDTH)) u_lzc_b (
      .data_i (abs_b),
      .cnt_o  (lz_b)
    );
  end else begin : g_nolzc
    assign lz_a = '0;
    assign lz_b = '0;
  end

  // PREP: magnitudes, special cases, iteration count, divisor
  always_comb begin
    sgn      = op_q[DIV_OP_SIGNED_BIT];
    sa       = sgn & a_q[WIDTH-1];
    sb       = sgn & b_q[WIDTH-1];
    abs_a    = sa ? (~a_q + 1'b1) : a_q;
    abs_b    = sb ? (~b_q + 1'b1) : b_q;
    div_zero = (b_q == '0);
    ovf      = sgn & (a_q == MIN_VAL) & (b_q == ONES);
    n_iter   = '0;
    if (div_zero || ovf) begin
      n_iter = '0;
    end else if (EARLY_OUT != 0) begin
      if (abs_a >= abs_b) begin
        n_iter = lz_b - lz_a + CW'(1);
      end
    end else begin
      n_iter = CW'(WIDTH);
    end
    n_sh     = (n_iter != '0) ? n_iter - CW'(1) : '0;
    dvs_init = {{WIDTH{1'b0}}, abs_b} << n_sh;
  end

  // RUN: one restoring step plus final sign correction
  always_comb begin
    step_ge = ({{WIDTH{1'b0}}, rem_q} >= dvs_q);
    rem_sub = rem_q - dvs_q[WIDTH-1:0];
    quo_fix = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;
  end

  // control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (!kill_i && in_valid_i) begin
            op_q       <= op_i;
            a_q        <= op_a_i;
            b_q        <= op_b_i;
            state_q    <= DIV_PREP;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        DIV_PREP: begin
          if (kill_i) begin
            state_q    <= DIV_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            cnt_q   <= n_iter;
            dvs_q   <= dvs_init;
            state_q <= DIV_RUN;
            if (div_zero) begin
              quo_q   <= ONES;
              rem_q   <= a_q;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
            end else if (ovf) begin
              quo_q   <= MIN_VAL;
              rem_q   <= '0;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
            end else begin
              quo_q   <= '0;
              rem_q   <= abs_a;
              q_neg_q <= sa ^ sb;
              r_neg_q <= sa;
            end
          end
        end
        DIV_RUN: begin
          if (kill_i) begin
            state_q    <= DIV_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (cnt_q == '0) begin
            result_q    <= op_q[DIV_OP_REM_BIT] ?
                           rem_fix : quo_fix;
            state_q     <= DIV_DONE;
            out_valid_q <= 1'b1;
          end else begin
            if (step_ge) begin
              rem_q <= rem_sub;
            end
            quo_q <= {quo_q[WIDTH-2:0], step_ge};
            dvs_q <= dvs_q >> 1;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DIV_DONE: begin
          if (kill_i || out_ready_i) begin
            state_q     <= DIV_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= DIV_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_riscv_div_seq.sv
// tb_riscv_div_seq: directed checks of the sequential divider.
// Three instances: 32-bit early-out, 32-bit full, 8-bit early-out.
module tb_riscv_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        kill;
  logic        out_ready;
  int          sel;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic        bsy0, bsy1, bsy2;
  logic [31:0] res0, res1;
  logic [7:0]  res2;

  logic        obs_rdy;
  logic        obs_vld;
  logic [31:0] obs_res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_div_seq #(.WIDTH(32), .EARLY_OUT(1)) u_eo (
    .clk         (clk),
    .rst         (rst),
    .op_i        (op),
    .op_a_i      (a),
    .op_b_i      (b),
    .in_valid_i  (in_valid && sel == 0),
    .in_ready_o  (rdy0),
    .kill_i      (kill),
    .out_valid_o (vld0),
    .out_ready_i (out_ready),
    .result_o    (res0),
    .busy_o      (bsy0)
  );

  riscv_div_seq #(.WIDTH(32), .EARLY_OUT(0)) u_full (
    .clk         (clk),
    .rst         (rst),
    .op_i        (op),
    .op_a_i      (a),
    .op_b_i      (b),
    .in_valid_i  (in_valid && sel == 1),
    .in_ready_o  (rdy1),
    .kill_i      (kill),
    .out_valid_o (vld1),
    .out_ready_i (out_ready),
    .result_o    (res1),
    .busy_o      (bsy1)
  );

  riscv_div_seq #(.WIDTH(8), .EARLY_OUT(1)) u_w8 (
    .clk         (clk),
    .rst         (rst),
    .op_i        (op),
    .op_a_i      (a[7:0]),
    .op_b_i      (b[7:0]),
    .in_valid_i  (in_valid && sel == 2),
    .in_ready_o  (rdy2),
    .kill_i      (kill),
    .out_valid_o (vld2),
    .out_ready_i (out_ready),
    .result_o    (res2),
    .busy_o      (bsy2)
  );

  assign obs_rdy = (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
  assign obs_vld = (sel == 0) ? vld0 : (sel == 1) ? vld1 : vld2;
  assign obs_res = (sel == 0) ? res0 :
                   (sel == 1) ? res1 : {24'h0, res2};

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int s, input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y);
    int n;
    n   = 0;
    sel = s;
    #0;
    while (!obs_rdy && n < 60) begin
      tick();
      n++;
    end
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run(input int s, input logic [1:0] o,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] er,
                     input int el, input string tag);
    int n;
    launch(s, o, x, y);
    n = 0;
    while (!obs_vld && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(el));
    chk({tag, " result"}, {32'h0, obs_res}, {32'h0, er});
  endtask

  initial begin
    int pulses;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    kill      = 1'b0;
    out_ready = 1'b1;
    sel       = 0;

    repeat (3) tick();
    chk("rst in_ready", {63'h0, rdy0}, 64'h1);
    chk("rst out_valid", {63'h0, vld0}, 64'h0);
    chk("rst busy", {63'h0, bsy0}, 64'h0);
    chk("rst result", {32'h0, res0}, 64'h0);
    chk("rst full rdy", {63'h0, rdy1}, 64'h1);
    chk("rst w8 rdy", {63'h0, rdy2}, 64'h1);
    rst = 1'b0;
    tick();

    run(0, 2'b00, 32'd100, 32'd7, 32'd14, 7, "divu 100/7");
    run(0, 2'b10, 32'd100, 32'd7, 32'd2, 7, "remu 100/7");
    run(0, 2'b01, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFD, 4, "div -7/2");
    run(0, 2'b11, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFF, 4, "rem -7/2");
    run(0, 2'b01, 32'd7, 32'hFFFFFFFE,
        32'hFFFFFFFD, 4, "div 7/-2");
    run(0, 2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 4, "rem 7/-2");
    run(0, 2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, 2, "divu 5/0");
    run(0, 2'b10, 32'd5, 32'd0, 32'd5, 2, "remu 5/0");
    run(0, 2'b11, 32'hFFFFFFFB, 32'd0,
        32'hFFFFFFFB, 2, "rem -5/0");
    run(0, 2'b01, 32'h80000000, 32'hFFFFFFFF,
        32'h80000000, 2, "div min/-1");
    run(0, 2'b11, 32'h80000000, 32'hFFFFFFFF,
        32'd0, 2, "rem min/-1");
    run(0, 2'b00, 32'd3, 32'd10, 32'd0, 2, "divu 3/10");

    run(1, 2'b00, 32'hFFFFFFFF, 32'd1,
        32'hFFFFFFFF, 34, "full divu max/1");
    run(1, 2'b01, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFD, 34, "full div -7/2");

    run(2, 2'b01, 32'h80, 32'hFF, 32'h80, 2, "w8 div 80/ff");
    run(2, 2'b00, 32'd200, 32'd3, 32'd66, 9, "w8 divu 200/3");

    out_ready = 1'b0;
    run(0, 2'b00, 32'd100, 32'd7, 32'd14, 7, "bp divu");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp valid", {63'h0, vld0}, 64'h1);
      chk("bp result", {32'h0, res0}, 64'd14);
      chk("bp in_ready", {63'h0, rdy0}, 64'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp release valid", {63'h0, vld0}, 64'h0);
    chk("bp release rdy", {63'h0, rdy0}, 64'h1);
    chk("bp result hold", {32'h0, res0}, 64'd14);

    launch(0, 2'b00, 32'hFFFFFFFF, 32'd1);
    tick();
    repeat (3) tick();
    chk("kill busy before", {63'h0, bsy0}, 64'h1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill busy", {63'h0, bsy0}, 64'h0);
    chk("kill in_ready", {63'h0, rdy0}, 64'h1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (vld0) pulses++;
      tick();
    end
    chk("kill no valid", 64'(pulses), 64'h0);

    launch(0, 2'b00, 32'hFFFFFFFF, 32'd1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst in_ready", {63'h0, rdy0}, 64'h1);
    chk("mid rst valid", {63'h0, vld0}, 64'h0);
    chk("mid rst busy", {63'h0, bsy0}, 64'h0);
    chk("mid rst result", {32'h0, res0}, 64'h0);

    op       = 2'b00;
    a        = 32'd100;
    b        = 32'd7;
    in_valid = 1'b1;
    kill     = 1'b1;
    tick();
    in_valid = 1'b0;
    kill     = 1'b0;
    chk("idle kill busy", {63'h0, bsy0}, 64'h0);
    chk("idle kill rdy", {63'h0, rdy0}, 64'h1);
    repeat (3) tick();
    chk("idle kill valid", {63'h0, vld0}, 64'h0);

    run(0, 2'b00, 32'd100, 32'd7, 32'd14, 7, "after kill");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_div_seq.md
Name: riscv_div_seq

Overview:
- Parametrised multi-cycle integer divider/remainder unit for the EX stage.
- Implements the ALU_DIVU/DIV/REMU/REM encodings: op bit0 selects signed, op bit1 selects remainder.
- Generalises the fixed 32-bit serial divider with:
  - a WIDTH parameter,
  - optional early-out normalisation,
  - a valid/ready result handshake with backpressure,
  - a kill input for pipeline flushes.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- EARLY_OUT, 1, 1 = skip leading-zero iterations via normalisation; 0 = always WIDTH iterations.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- op_i  input  2  bit0 signed, bit1 remainder (low bits of ALU_DIV* opcodes).
- op_a_i  input  WIDTH  dividend.
- op_b_i  input  WIDTH  divisor.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  unit can accept a request (high only in IDLE).
- kill_i  input  1  abort current operation (flush).
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- result_o  output  WIDTH  quotient or remainder.
- busy_o  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - State is IDLE.
  - in_ready_o=1; out_valid_o=0; busy_o=0; result_o=0.
  - Internal registers are 0.
- Accept: the request is taken on the edge where in_valid_i & in_ready_o. Operands and op are captured that edge; state becomes PREP.
- PREP (1 cycle):
  - Form |a|, |b| (signed mode only); record result sign.
    - Quotient sign = sa^sb.
    - Remainder sign = sa.
  - Compute iteration count N:
    - EARLY_OUT=1: N = lzc(|b|) - lzc(|a|) + 1 if |a|>=|b|, else 0. The divisor is pre-shifted left by N-1.
    - EARLY_OUT=0: N = WIDTH.
  - Special cases resolved here with N forced to 0:
    - b==0: quotient all-ones; remainder = a (unmodified).
    - Signed a==MIN and b==-1: quotient = MIN; remainder = 0.
- DIV (N cycles): restoring division, one quotient bit per cycle. A down-counter is held in clog2(WIDTH+1) bits. Sign correction is applied on the final step.
- DONE:
  - out_valid_o=1 with result_o stable.
  - Leaves to IDLE on the edge where out_ready_i=1.
  - result_o holds its value after leaving DONE until the next DONE.
- Latency: out_valid_o first high N+2 cycles after the accept edge. Range is 2 to WIDTH+2 (EARLY_OUT=0 gives WIDTH+2).
- Throughput: at most one outstanding operation. No new accept in the DONE→IDLE transition cycle, because in_ready_o is registered from state.
- Backpressure: DONE is held indefinitely while out_ready_i=0; result_o must not change.
- kill_i:
  - In PREP, DIV or DONE: next state is IDLE, no out_valid_o pulse afterwards.
  - In IDLE: kill_i has priority over in_valid_i, so a same-cycle request is dropped.
- rst has priority over kill_i and all handshakes. Mid-operation reset returns to reset values on the next edge.
- Unsigned mode: MSBs are data; no sign handling.
- Inputs are sampled only at accept; changes during an operation are ignored.

Decomposition:
- Add to riscv_defines:
  - DIV_OP_SIGNED_BIT=0 and DIV_OP_REM_BIT=1.
  - Typedef enum logic[1:0] div_state_t {DIV_IDLE, DIV_PREP, DIV_RUN, DIV_DONE}.
- One sub-module: riscv_div_lzc.
  - Parametrised WIDTH leading-zero counter; all-zero input returns WIDTH.
  - Instantiated twice, for |a| and |b|.
  - Unused (tie-off) when EARLY_OUT=0.

Test Plan (WIDTH=32 unless stated):
1. DIVU 100/7, EARLY_OUT=1 → result 14, out_valid 7 cycles after accept (N=5). REMU 100/7 → 2.
2. DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIV 7/-2 → -3; REM 7/-2 → 1.
3. DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Each with out_valid at 2 cycles. DIVU 3/10 → 0 at 2 cycles.
4. EARLY_OUT=0, DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF at 34 cycles. WIDTH=8 instance: DIV 0x80/0xFF → 0x80; DIVU 200/3 → 66.
5. out_ready_i low for 10 cycles in DONE → out_valid and result stable, in_ready_o=0. Release → IDLE next edge, in_ready_o=1.
6. kill_i asserted 3 cycles into DIV → IDLE next edge, no out_valid. rst asserted mid-DIV → all outputs at reset values next edge. kill_i with in_valid_i in IDLE → no accept.
